// File: rtl/irq_arbiter.sv
// Interrupt arbiter: edge-detects sources into PEND, masks and picks a winner, and runs the
// CPU Ireq/Iack handshake. Define IRQ_ROUND_ROBIN_EN to rotate priority after each service.
module irq_arbiter #(
  parameter int N_SRC = 8,
  parameter int ID_W  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_in,
  output logic             Ireq,
  input  logic             Iack,
  input  logic             sel,
  input  logic             mem_w,
  input  logic [1:0]       addr,
  input  logic [31:0]      data_in,
  output logic [31:0]      data_out,
  output logic             active
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_e;

  state_e           state_q, state_d;
  logic [N_SRC-1:0] irq_prev_q, pend_q, pend_d, mask_q, mask_d;
  logic             ireq_q, ireq_d, active_q, active_d;
  logic             cause_vld_q, cause_vld_d, cause_spur_q, cause_spur_d;
  logic [ID_W-1:0]  cause_id_q, cause_id_d;
  logic [N_SRC-1:0] rise, eligible, win_oh, pend_clr;
  logic [ID_W-1:0]  win_id;
  logic             any_elig, wr_en, pend_wr, mask_wr, eoi_wr, ack_take, eoi_take;
  logic             unused_data;

  assign rise        = irq_in & ~irq_prev_q;
  assign eligible    = pend_q & mask_q;
  assign any_elig    = |eligible;
  assign wr_en       = sel & mem_w;
  assign pend_wr     = wr_en && (addr == 2'd0);
  assign mask_wr     = wr_en && (addr == 2'd1);
  assign eoi_wr      = wr_en && (addr == 2'd3);
  assign unused_data = ^data_in[31:N_SRC];

`ifdef IRQ_ROUND_ROBIN_EN
  logic [ID_W-1:0] last_id_q, last_id_d;

  // Scan downward so the index closest after last_id is the final (winning) assignment.
  always_comb begin
    int idx;
    idx    = 0;
    win_id = '0;
    win_oh = '0;
    for (int k = N_SRC; k >= 1; k--) begin
      idx = (int'(last_id_q) + k) % N_SRC;
      if (eligible[idx]) begin
        win_id      = ID_W'(idx);
        win_oh      = '0;
        win_oh[idx] = 1'b1;
      end
    end
  end

  assign last_id_d = (ack_take && any_elig) ? win_id : last_id_q;

  always_ff @(posedge clk) begin
    if (reset) last_id_q <= '0;
    else       last_id_q <= last_id_d;
  end
`else
  always_comb begin
    win_id = '0;
    win_oh = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        win_id    = ID_W'(i);
        win_oh    = '0;
        win_oh[i] = 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_elig) state_d = REQ;
      REQ: begin
        if (Iack)           state_d = SERVICE;
        else if (!any_elig) state_d = IDLE;
      end
      SERVICE: if (eoi_wr) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ack_take     = (state_q == REQ) && Iack;
    eoi_take     = (state_q == SERVICE) && eoi_wr;
    ireq_d       = (state_d == REQ);
    active_d     = active_q;
    cause_vld_d  = cause_vld_q;
    cause_spur_d = cause_spur_q;
    cause_id_d   = cause_id_q;
    if (ack_take) begin
      active_d     = 1'b1;
      cause_vld_d  = 1'b1;
      cause_spur_d = !any_elig;
      cause_id_d   = any_elig ? win_id : '0;
    end else if (eoi_take) begin
      active_d    = 1'b0;
      cause_vld_d = 1'b0;
    end
    // Iack works on pre-write PEND; a same-cycle rising edge beats any clear.
    pend_clr = pend_wr ? data_in[N_SRC-1:0] : '0;
    if (ack_take) pend_clr = pend_clr | win_oh;
    pend_d = (pend_q & ~pend_clr) | rise;
    mask_d = mask_wr ? data_in[N_SRC-1:0] : mask_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_prev_q   <= '0;
      pend_q       <= '0;
      mask_q       <= '0;
      ireq_q       <= 1'b0;
      active_q     <= 1'b0;
      cause_vld_q  <= 1'b0;
      cause_spur_q <= 1'b0;
      cause_id_q   <= '0;
    end else begin
      irq_prev_q   <= irq_in;
      pend_q       <= pend_d;
      mask_q       <= mask_d;
      ireq_q       <= ireq_d;
      active_q     <= active_d;
      cause_vld_q  <= cause_vld_d;
      cause_spur_q <= cause_spur_d;
      cause_id_q   <= cause_id_d;
    end
  end

  always_comb begin
    data_out = '0;
    case (addr)
      2'd0:    data_out = {{(32-N_SRC){1'b0}}, pend_q};
      2'd1:    data_out = {{(32-N_SRC){1'b0}}, mask_q};
      2'd2:    data_out = {cause_vld_q, cause_spur_q, {(30-ID_W){1'b0}}, cause_id_q};
      default: data_out = '0;
    endcase
  end

  assign Ireq   = ireq_q;
  assign active = active_q;

endmodule
